// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID latch.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int INSTR_W = 32;
  localparam int NPC_W   = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Branch targets are byte addresses; fetch only ever uses word-aligned PCs.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle between fetch, hazard unit, instruction memory and decode.
// Latency: none (wires only).
// Backpressure: stall is the only hold control; no ready signal exists.
interface fetch_stage_if #(
  parameter int ADDR_W = 7
);
  import fetch_stage_pkg::*;

  logic                stall;
  logic                pc_src;
  logic [31:0]         branch_target;
  logic                flush;
  logic [ADDR_W-1:0]   imem_addr;
  logic [31:0]         imem_data;
  logic [INSTR_W-1:0]  if_id_instr;
  logic [NPC_W-1:0]    if_id_npc;
  logic                if_id_valid;
  logic                halted;
  logic [15:0]         fetch_count;

  // Fetch stage side.
  modport master (
    input  stall, pc_src, branch_target, flush, imem_data,
    output imem_addr, if_id_instr, if_id_npc, if_id_valid, halted, fetch_count
  );

  // Environment side: hazard unit, MEM branch logic, imem and decode.
  modport slave (
    output stall, pc_src, branch_target, flush, imem_data,
    input  imem_addr, if_id_instr, if_id_npc, if_id_valid, halted, fetch_count
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline latch: instruction, PC+4 and valid bit.
// Latency: 1 cycle from load/bubble to outputs.
// Backpressure: holds contents when neither load nor bubble is asserted.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_W = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [NPC_W-1:0]   npc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [NPC_W-1:0]   npc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [NPC_W-1:0]   npc_q, npc_d;
  logic               valid_q, valid_d;

  // Bubble wins over load; with neither the latch simply holds.
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (bubble_i) begin
      instr_d = NOP_W;
      npc_d   = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      npc_d   = npc_i;
      valid_d = 1'b1;
    end
  end

  // Register the latch; reset leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q <= NOP_W;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Program counter, fetch FSM (BOOT/RUN/HALT) and IF/ID capture for the 5-stage pipe.
// Latency: imem_addr combinational from pc; IF/ID updates 1 cycle after fetch.
// Backpressure: stall freezes pc and IF/ID; pc_src overrides stall; flush bubbles IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W = 7,
  parameter logic [31:0] NOP_W  = NOP_WORD,
  parameter logic [31:0] HALT_W = HALT_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4;
  logic         halted_q;
  logic [15:0]  count_q;

  logic         ifid_load;
  logic         ifid_bubble;
  logic         take_halt;

  assign pc_plus4      = pc_q + 32'd4;
  assign bus.imem_addr = pc_q[ADDR_W+1:2];

  // Decode this cycle's IF/ID action from state and pipeline controls.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    take_halt   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.pc_src || bus.flush) begin
          // Wrong-path fetch or explicit flush: discard whatever imem returns.
          ifid_bubble = 1'b1;
        end else if (!bus.stall) begin
          if (bus.imem_data == HALT_W) begin
            // The halt word itself never enters decode.
            ifid_bubble = 1'b1;
            take_halt   = 1'b1;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      HALT:    ifid_bubble = 1'b1;
      default: ;
    endcase
  end

  // PC, fetch FSM, halted flag and valid-fetch counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= BOOT;
      pc_q     <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (ifid_load && count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (bus.pc_src) begin
            pc_q <= word_align(bus.branch_target);
          end else if (!bus.stall) begin
            if (take_halt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        HALT: begin
          // A redirect means the halt word came down a mispredicted path.
          if (bus.pc_src) begin
            pc_q     <= word_align(bus.branch_target);
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  // Only bits [ADDR_W+1:2] address imem; the low target bits are dropped by alignment.
  logic unused_bits;
  assign unused_bits = ^bus.branch_target[1:0];

  if_id_reg #(
    .NOP_W (NOP_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .instr_i  (bus.imem_data),
    .npc_i    (pc_plus4),
    .instr_o  (bus.if_id_instr),
    .npc_o    (bus.if_id_npc),
    .valid_o  (bus.if_id_valid)
  );

  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Program-counter and IF/ID pipeline-register block for the five-stage pipeline. Drives the word address into the combinational instruction memory, captures the returned instruction plus PC+4 into the IF/ID latch, and handles hazard stalls, branch redirects from MEM, flushes and a halt word. Sits directly upstream of instruction memory and directly feeds the decode stage.

## Interface
- `ADDR_W`, 7: instruction-memory word-address width (128 words).
- `NOP_WORD`, 32'h0000_0000: bubble instruction written into IF/ID.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction that stops fetch.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `stall` input 1: hazard unit freezes PC and IF/ID.
- `pc_src` input 1: branch taken (from MEM); redirect PC.
- `branch_target` input 32: byte address to redirect to.
- `flush` input 1: replace IF/ID contents with a bubble.
- `imem_addr` output ADDR_W: `pc[ADDR_W+1:2]`, to instruction memory.
- `imem_data` input 32: instruction from memory, same cycle.
- `if_id_instr` output 32: latched instruction.
- `if_id_npc` output 32: latched PC+4 of that instruction.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `halted` output 1: fetch stopped on HALT_WORD.
- `fetch_count` output 16: instructions latched valid, saturating.

## Operation
- States: BOOT, RUN, HALT.
  - BOOT: one cycle after reset release; no capture; goes to RUN.
  - RUN: normal fetch.
  - HALT: PC frozen; IF/ID loaded with NOP_WORD, valid 0, each cycle.
- Reset (rst=0 at an edge): pc=0, state=BOOT, if_id_instr=NOP_WORD, if_id_npc=0, if_id_valid=0, halted=0, fetch_count=0. Reset mid-operation discards everything at that edge.
- Per-edge priority in RUN: reset > pc_src > stall > normal.
  - pc_src: pc←{branch_target[31:2],2'b00}. IF/ID←bubble (wrong-path fetch discarded). Overrides a simultaneous stall.
  - flush without pc_src: IF/ID←bubble, PC advances unless stall.
  - stall (no pc_src): pc and IF/ID hold unchanged; a simultaneous flush still bubbles IF/ID.
  - normal: IF/ID←{imem_data, pc+4, valid 1}, pc←pc+4.
- HALT_WORD capture under normal advance: IF/ID takes bubble (not the halt word). PC holds. State→HALT, halted=1.
- In HALT, pc_src redirects and returns to RUN (halt word was fetched down a wrong path). halted clears. stall/flush are ignored.
- PC is 32-bit with 2^32 wrap. imem_addr truncates, so fetch wraps at 128 words; if_id_npc keeps the full 32-bit value.
- fetch_count increments when if_id_valid is written 1; holds at 16'hFFFF.

## Timing
- imem_addr is combinational from pc; imem_data is used in the same cycle.
- Fetch-to-IF/ID latency: 1 cycle. Branch penalty as seen here: 1 bubble after redirect edge.
- All outputs are registered except imem_addr.
- BOOT costs exactly one cycle. First valid instruction (address 0) appears in IF/ID after the 2nd edge with rst=1.

## Structure
- Shared pipeline package holds: NOP_WORD, HALT_WORD, state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the IF/ID field widths.
- One natural sub-module: `if_id_reg`, holding instr/npc/valid with load, hold and bubble controls.
- The PC/state machine stays in `fetch_stage`.

## Test plan
- Reset, then memory words 0..3 = 0x11,0x22,0x33,0x44 → after edges 2..5, if_id_instr=0x11,0x22,0x33,0x44; if_id_npc=4,8,12,16; fetch_count=4.
- stall held 3 cycles while pc=8 → IF/ID and imem_addr unchanged for 3 cycles, then 0x33 with npc=12.
- pc_src=1 with branch_target=0x43 and stall=1 at pc=12 → next pc=0x40; 1 bubble (valid 0); then imem_addr=16 and that word latched.
- word 5 = HALT_WORD → halted=1, IF/ID bubble, pc holds 20; then pc_src to 0 → RUN, halted=0, word 0 fetched.
- rst=0 for one edge mid-run with valid data in IF/ID → all outputs at reset values, BOOT, fetch resumes at address 0.
- pc=0x1FC (word 127) → next imem_addr=0, if_id_npc=0x200.
